rr_req_arbiter: RTL

Round-robin arbiter that shares one downstream resource among `N` requesters and sequences each ownership period. It combines the request lines into a single "any request" indication and issues a registered one-hot grant. Each grant is held until the owner signals `done`, drops its request, or a hold timeout expires. The block sits between the gate-level request logic and the shared resource it guards.

---
 rtl/rr_req_arbiter_pkg.sv | 20 ++
 rtl/rr_req_arbiter_pick.sv | 35 +++
 rtl/rr_req_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/rr_req_arbiter_pkg.sv
// rtl/rr_req_arbiter_pkg.sv - shared constants and state encoding for the round-robin arbiter
package rr_req_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int N_DEF        = 4;
    localparam int MAX_HOLD_DEF = 15;
    localparam int CW_DEF       = 8;

    // Index width for an N-entry pointer; a 1-bit floor keeps N=1 corner legal
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PTR_W_DEF = ptr_width(N_DEF);

endpackage

// File: rtl/rr_req_arbiter_pick.sv
// rtl/rr_req_arbiter_pick.sv - combinational round-robin picker starting at a pointer
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  pick_o,
    output logic          valid_o
);

    // Scan ptr, ptr+1, ... with wrap; the first set request wins
    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        int            s;
        pick_o = '0;
        found  = 1'b0;
        idx    = '0;
        s      = 0;
        for (int i = 0; i < N; i++) begin
            s = int'(ptr_i) + i;
            if (s >= N) begin
                s = s - N;
            end
            idx = s[PW-1:0];
            if (!found && req_i[idx]) begin
                pick_o[idx] = 1'b1;
                found       = 1'b1;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/rr_req_arbiter.sv
// rtl/rr_req_arbiter.sv - round-robin arbiter with done/drop/timeout release
module rr_req_arbiter
    import rr_req_arbiter_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int CW       = CW_DEF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    input  logic         done_i,
    output logic [N-1:0] gnt_o,
    output logic         busy_o,
    output logic         any_req_o,
    output logic         timeout_o
);

    localparam int PW = ptr_width(N);

    arb_state_e    state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic          busy_q, busy_d;
    logic          timeout_q, timeout_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;

    logic [N-1:0]  pick;
    logic          pick_valid;
    logic [PW-1:0] owner;
    logic          rel_done, rel_drop, rel_limit;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .pick_o  (pick),
        .valid_o (pick_valid)
    );

    // Request summary is a pure OR, visible in the same cycle
    always_comb begin
        any_req_o = |req_i;
    end

    // Owner index recovered from the one-hot grant register
    always_comb begin
        owner = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_q[i]) begin
                owner = PW'(i);
            end
        end
    end

    // Next-state and output register inputs for the IDLE/GRANT machine
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        busy_d     = busy_q;
        timeout_d  = 1'b0;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        rel_done   = done_i;
        rel_drop   = ~req_i[owner];
        rel_limit  = (hold_cnt_q == CW'(MAX_HOLD));

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    gnt_d      = pick;
                    busy_d     = 1'b1;
                    hold_cnt_d = CW'(1);
                    state_d    = ST_GRANT;
                end else begin
                    gnt_d  = '0;
                    busy_d = 1'b0;
                end
            end
            ST_GRANT: begin
                if (rel_done || rel_drop || rel_limit) begin
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                    // Pulse only when the hold limit alone forced the release
                    timeout_d = rel_limit && !rel_done && !rel_drop;
                    ptr_d     = (owner == PW'(N - 1)) ? '0 : owner + PW'(1);
                end else begin
                    hold_cnt_d = hold_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, pointer, counter and output registers with asynchronous clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign busy_o    = busy_q;
    assign timeout_o = timeout_q;

endmodule
